// File: rtl/floating_point_div_if.sv
// Operand/result bundle for the iterative single-precision divider.
// The sequencer side (master) launches operations; the divider (slave) answers.
interface floating_point_div_if #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
);
    localparam int W = 1 + EXP_WIDTH + MANT_WIDTH;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Quotient;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         invalid;

    modport master (
        output start, A, B,
        input  Quotient, busy, done, div_by_zero, invalid
    );

    modport slave (
        input  start, A, B,
        output Quotient, busy, done, div_by_zero, invalid
    );
endinterface

// File: rtl/floating_point_div.sv
// Iterative IEEE-754 divider: Quotient = A / B.
// Restoring mantissa division retires one quotient bit per cycle; the result is
// truncated toward zero and denormals are flushed to +0. Special operands
// (zero, denormal, inf, NaN) short-circuit through a single-cycle SPECIAL state.
module floating_point_div #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic                clk,
    input  logic                rst,
    floating_point_div_if.slave bus
);
    localparam int W      = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int MW     = MANT_WIDTH + 1;          // mantissa with hidden bit
    localparam int QW     = MANT_WIDTH + 2;          // quotient / remainder width
    localparam int DW     = EXP_WIDTH + 2;           // signed exponent difference
    localparam int ITER   = MANT_WIDTH + 2;          // divide iterations
    localparam int CW     = $clog2(ITER + 1);
    localparam int BIAS_I = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
    localparam logic signed [DW-1:0] BIAS    = DW'(BIAS_I);
    localparam logic signed [DW-1:0] BIAS_M1 = DW'(BIAS_I - 1);
    localparam logic signed [DW-1:0] EXP_SAT = {2'b00, EXP_MAX};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPECIAL = 2'd1,
        DIVIDE  = 2'd2,
        NORM    = 2'd3
    } state_t;

    state_t state_q, state_next;

    // Latched operand fields
    logic                   sign_q;
    logic [EXP_WIDTH-1:0]   ea_q, eb_q;
    logic [MANT_WIDTH-1:0]  fa_q, fb_q;
    logic signed [DW-1:0]   diff_q;

    // Divider datapath
    logic [QW-1:0] rem_q, quo_q;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] divisor;
    logic          bit_ge;
    logic [QW-1:0] rem_sub;

    // Result registers
    logic [W-1:0] quotient_q;
    logic         done_q, dbz_q, invalid_q;

    // FSM control strobes
    logic load, iterate, wr_special, wr_norm;

    // Incoming operand fields (only meaningful when start is accepted)
    logic [EXP_WIDTH-1:0] in_ea, in_eb;
    logic                 in_special;

    // Special-case resolution; returns {word, invalid, div_by_zero}.
    function automatic logic [W+1:0] special_result(
        input logic                  s,
        input logic [EXP_WIDTH-1:0]  ea,
        input logic [EXP_WIDTH-1:0]  eb,
        input logic [MANT_WIDTH-1:0] fa,
        input logic [MANT_WIDTH-1:0] fb
    );
        logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [W-1:0] qnan, inf;
        nan_a  = (ea == EXP_MAX) && (fa != '0);
        nan_b  = (eb == EXP_MAX) && (fb != '0);
        inf_a  = (ea == EXP_MAX) && (fa == '0);
        inf_b  = (eb == EXP_MAX) && (fb == '0);
        zero_a = (ea == '0);
        zero_b = (eb == '0);
        qnan   = {1'b0, EXP_MAX, 1'b1, {(MANT_WIDTH-1){1'b0}}};
        inf    = {s, EXP_MAX, {MANT_WIDTH{1'b0}}};
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            return {qnan, 1'b1, 1'b0};
        else if (inf_a)
            return {inf, 1'b0, 1'b0};
        else if (zero_b)
            return {inf, 1'b0, 1'b1};
        else
            return {{W{1'b0}}, 1'b0, 1'b0};
    endfunction

    // Normalise the raw quotient, then saturate to inf or flush to +0.
    function automatic logic [W-1:0] norm_result(
        input logic                 s,
        input logic signed [DW-1:0] diff,
        input logic [QW-1:0]        q
    );
        logic signed [DW-1:0]  e;
        logic [MANT_WIDTH-1:0] frac;
        if (q[QW-1]) begin
            frac = q[QW-2:1];
            e    = diff + BIAS;
        end else begin
            frac = q[QW-3:0];
            e    = diff + BIAS_M1;
        end
        if (e >= EXP_SAT)
            return {s, EXP_MAX, {MANT_WIDTH{1'b0}}};
        else if (e[DW-1] || (e == '0))
            return '0;
        else
            return {s, e[EXP_WIDTH-1:0], frac};
    endfunction

    assign in_ea      = bus.A[W-2 -: EXP_WIDTH];
    assign in_eb      = bus.B[W-2 -: EXP_WIDTH];
    assign in_special = (in_ea == '0) || (in_ea == EXP_MAX) ||
                        (in_eb == '0) || (in_eb == EXP_MAX);

    assign divisor = {1'b0, 1'b1, fb_q};
    assign bit_ge  = (rem_q >= divisor);
    assign rem_sub = bit_ge ? (rem_q - divisor) : rem_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_next;
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_next = state_q;
        load       = 1'b0;
        iterate    = 1'b0;
        wr_special = 1'b0;
        wr_norm    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = in_special ? SPECIAL : DIVIDE;
                end
            end
            SPECIAL: begin
                wr_special = 1'b1;
                state_next = IDLE;
            end
            DIVIDE: begin
                iterate = 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_next = NORM;
            end
            NORM: begin
                wr_norm    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and restoring divide iterations (no reset: data only)
    always_ff @(posedge clk) begin
        if (load) begin
            sign_q <= bus.A[W-1] ^ bus.B[W-1];
            ea_q   <= in_ea;
            eb_q   <= in_eb;
            fa_q   <= bus.A[MANT_WIDTH-1:0];
            fb_q   <= bus.B[MANT_WIDTH-1:0];
            diff_q <= $signed({2'b00, in_ea}) - $signed({2'b00, in_eb});
            rem_q  <= {1'b0, 1'b1, bus.A[MANT_WIDTH-1:0]};
            quo_q  <= '0;
            cnt_q  <= '0;
        end else if (iterate) begin
            rem_q <= {rem_sub[QW-2:0], 1'b0};
            quo_q <= {quo_q[QW-2:0], bit_ge};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result, flags and done pulse; all are rewritten on every completed operation
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_q <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            done_q <= wr_special | wr_norm;
            if (wr_special) begin
                {quotient_q, invalid_q, dbz_q} <=
                    special_result(sign_q, ea_q, eb_q, fa_q, fb_q);
            end else if (wr_norm) begin
                quotient_q <= norm_result(sign_q, diff_q, quo_q);
                invalid_q  <= 1'b0;
                dbz_q      <= 1'b0;
            end
        end
    end

    assign bus.Quotient    = quotient_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.invalid     = invalid_q;

    // MW documents the mantissa width used by the divisor above
    if (MW != MANT_WIDTH + 1) begin : g_bad_width
        $error("inconsistent mantissa width");
    end
endmodule

// File: tb/tb_floating_point_div.sv
// Bench for floating_point_div: directed vector table, handshake sequences and
// randomized operands checked against a truncating reference quotient model.
module tb_floating_point_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    floating_point_div_if bus ();

    floating_point_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
        logic        inv;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Reference: exact quotient of the significands truncated to 24 bits.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t        r;
        logic        s;
        logic [7:0]  ea, eb, e8;
        logic [22:0] fa, fb;
        logic        nan_a, nan_b, inf_a, inf_b;
        longint      ma, mb, mant;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        nan_a = (ea == 8'hFF) && (fa != 0);
        nan_b = (eb == 8'hFF) && (fb != 0);
        inf_a = (ea == 8'hFF) && (fa == 0);
        inf_b = (eb == 8'hFF) && (fb == 0);
        r.a = a; r.b = b; r.dz = 1'b0; r.inv = 1'b0; r.lat = 1;
        if (nan_a || nan_b || (ea == 0 && eb == 0) || (inf_a && inf_b)) begin
            r.q = 32'h7FC00000; r.inv = 1'b1;
        end else if (inf_a) begin
            r.q = {s, 8'hFF, 23'd0};
        end else if (eb == 0) begin
            r.q = {s, 8'hFF, 23'd0}; r.dz = 1'b1;
        end else if (ea == 0 || inf_b) begin
            r.q = 32'h0;
        end else begin
            r.lat = 26;
            ma = longint'({1'b1, fa});
            mb = longint'({1'b1, fb});
            if (ma >= mb) begin
                mant = (ma << 23) / mb;
                e    = int'(ea) - int'(eb) + 127;
            end else begin
                mant = (ma << 24) / mb;
                e    = int'(ea) - int'(eb) + 126;
            end
            e8 = e[7:0];
            if (e >= 255)     r.q = {s, 8'hFF, 23'd0};
            else if (e <= 0)  r.q = 32'h0;
            else              r.q = {s, e8, mant[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       e = 8'hFF;
            3:       e = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
            4:       begin e = 8'($urandom_range(100, 150)); f = 23'd0; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Launch one operation from the cycle we are in; returns in the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic dz, output logic inv,
                          output int lat);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL timeout got no done want done within 40 cycles");
        end
        check("busy_at_done", 32'(bus.busy), 32'd0);
        q = bus.Quotient; dz = bus.div_by_zero; inv = bus.invalid;
    endtask

    initial begin
        logic [31:0] q;
        logic        dz, inv;
        int          lat, pulses;
        vec_t        ex;

        vecs.push_back('{32'h41380000, 32'h40000000, 32'h40B80000, 1'b0, 1'b0, 26});
        vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1});
        vecs.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1'b0, 1});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1, 1});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h3F800000, 32'h3FFFFFFF, 32'h3F000000, 1'b0, 1'b0, 26});
        vecs.push_back('{32'h80000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1});

        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", bus.Quotient, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        check("rst_invalid", 32'(bus.invalid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, dz, inv, lat);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
            check($sformatf("vec%0d_inv", i), 32'(inv), 32'(vecs[i].inv));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
        end

        // Start while busy is ignored
        bus.start = 1'b1; bus.A = 32'h41380000; bus.B = 32'h40000000;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0;
        repeat (9) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.A = 32'h3F800000; bus.B = 32'h3F800000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
        check("ignored_start_lat", 32'(lat), 32'd26);
        check("ignored_start_q", bus.Quotient, 32'h40B80000);
        @(posedge clk); #1;
        check("ignored_start_idle", 32'(bus.busy), 32'd0);

        // Back-to-back: second start issued in the done cycle of the first
        run_op(32'hBF800000, 32'h40400000, q, dz, inv, lat);
        check("b2b_first_q", q, 32'hBEAAAAAA);
        run_op(32'h3F800000, 32'h40400000, q, dz, inv, lat);
        check("b2b_second_q", q, 32'h3EAAAAAA);
        check("b2b_second_lat", 32'(lat), 32'd26);

        // Reset mid-operation aborts with no done pulse
        bus.start = 1'b1; bus.A = 32'h41380000; bus.B = 32'h40000000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_quotient", bus.Quotient, 32'h0);
        check("abort_done", 32'(bus.done), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            ex = model(gen_operand(), gen_operand());
            run_op(ex.a, ex.b, q, dz, inv, lat);
            check($sformatf("rnd%0d_q a=%h b=%h", i, ex.a, ex.b), q, ex.q);
            check($sformatf("rnd%0d_dbz", i), 32'(dz), 32'(ex.dz));
            check($sformatf("rnd%0d_inv", i), 32'(inv), 32'(ex.inv));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ex.lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
